// File: rtl/uart_cmd_ctrl.sv
// Command controller behind the UART receiver: parses 4-byte write frames (header, address, data,
// checksum), issues register writes and answers each complete frame with an ACK/NAK byte.
module uart_cmd_ctrl #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_done,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        reg_wr_en,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [15:0] frame_ok_cnt
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAddr = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StCsum = 3'd3;
  localparam logic [2:0] StResp = 3'd4;

  localparam logic [1:0] ErrCsum    = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrOverrun = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [7:0]  addr_sh_q, addr_sh_d;
  logic [7:0]  data_sh_q, data_sh_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        err_pulse_q, err_pulse_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] frame_ok_cnt_q, frame_ok_cnt_d;

  logic       in_frame;
  logic       timeout_hit;
  logic [7:0] csum_exp;

  assign in_frame = (state_q == StAddr) || (state_q == StData) || (state_q == StCsum);
  assign csum_exp = HEADER + addr_sh_q + data_sh_q;
  // The flag registers on the edge where the counter reaches TIMEOUT_CYCLES-1.
  assign timeout_hit = in_frame && !uart_rx_done && (tmo_cnt_q == TIMEOUT_CYCLES - 32'd2);

  always_comb begin
    state_d        = state_q;
    addr_sh_d      = addr_sh_q;
    data_sh_d      = data_sh_q;
    tmo_cnt_d      = '0;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    reg_wr_en_d    = 1'b0;
    reg_addr_d     = reg_addr_q;
    reg_wdata_d    = reg_wdata_q;
    err_pulse_d    = 1'b0;
    err_code_d     = err_code_q;
    frame_ok_cnt_d = frame_ok_cnt_q;

    if (in_frame && !uart_rx_done) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end

    case (state_q)
      StIdle: begin
        if (uart_rx_done && (uart_rx_data == HEADER)) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (uart_rx_done) begin
          addr_sh_d = uart_rx_data;
          state_d   = StData;
        end
      end
      StData: begin
        if (uart_rx_done) begin
          data_sh_d = uart_rx_data;
          state_d   = StCsum;
        end
      end
      StCsum: begin
        if (uart_rx_done) begin
          if (uart_rx_data == csum_exp) begin
            reg_wr_en_d    = 1'b1;
            reg_addr_d     = addr_sh_q;
            reg_wdata_d    = data_sh_q;
            frame_ok_cnt_d = frame_ok_cnt_q + 16'd1;
            tx_data_d      = ACK_BYTE;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ErrCsum;
            tx_data_d   = NAK_BYTE;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = StIdle;
        end
        // Bytes arriving while the response is pending are dropped.
        if (uart_rx_done) begin
          err_pulse_d = 1'b1;
          err_code_d  = ErrOverrun;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout_hit) begin
      err_pulse_d = 1'b1;
      err_code_d  = ErrTimeout;
      state_d     = StIdle;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= StIdle;
      addr_sh_q      <= '0;
      data_sh_q      <= '0;
      tmo_cnt_q      <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      reg_wr_en_q    <= 1'b0;
      reg_addr_q     <= '0;
      reg_wdata_q    <= '0;
      err_pulse_q    <= 1'b0;
      err_code_q     <= '0;
      frame_ok_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_sh_q      <= addr_sh_d;
      data_sh_q      <= data_sh_d;
      tmo_cnt_q      <= tmo_cnt_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      reg_wr_en_q    <= reg_wr_en_d;
      reg_addr_q     <= reg_addr_d;
      reg_wdata_q    <= reg_wdata_d;
      err_pulse_q    <= err_pulse_d;
      err_code_q     <= err_code_d;
      frame_ok_cnt_q <= frame_ok_cnt_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign reg_wr_en    = reg_wr_en_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wdata    = reg_wdata_q;
  assign err_pulse    = err_pulse_q;
  assign err_code     = err_code_q;
  assign frame_ok_cnt = frame_ok_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame vector table plus hand-written timeout, overrun and reset
// sequences; write/response/error events are checked against a scoreboard with expected cycles.
module tb_uart_cmd_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_rx_done = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [15:0] frame_ok_cnt;

  always #5 clk_in = ~clk_in;

  uart_cmd_ctrl #(
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .uart_rx_data(uart_rx_data),
    .uart_rx_done(uart_rx_done),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .reg_wr_en   (reg_wr_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .frame_ok_cnt(frame_ok_cnt)
  );

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  typedef logic [0:5][7:0] bytes_t;

  typedef struct {
    bytes_t      b;
    int          n;
    int          gap;
    bit          ok;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  tx;
    logic [15:0] cnt;
  } vec_t;

  exp_t wr_q[$];
  exp_t tx_q[$];
  exp_t err_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic match(input string name, input logic [15:0] act, input bit have, input exp_t e);
    if (!have) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: got unexpected event value %0h, want no event (cycle %0d)", name, act, cyc);
    end else begin
      check(name, 32'(act), 32'(e.val));
      check({name, "_cycle"}, 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Output monitor: each cycle a strobe is high consumes one expected event.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (reg_wr_en) begin : mon_wr
        exp_t e;
        bit   h;
        e = '{val: 16'h0, cyc: 0};
        h = (wr_q.size() > 0);
        if (h) e = wr_q.pop_front();
        match("reg_wr", {reg_addr, reg_wdata}, h, e);
      end
      if (tx_start) begin : mon_tx
        exp_t e;
        bit   h;
        e = '{val: 16'h0, cyc: 0};
        h = (tx_q.size() > 0);
        if (h) e = tx_q.pop_front();
        match("tx_start", {8'h00, tx_data}, h, e);
      end
      if (err_pulse) begin : mon_err
        exp_t e;
        bit   h;
        e = '{val: 16'h0, cyc: 0};
        h = (err_q.size() > 0);
        if (h) e = err_q.pop_front();
        match("err_pulse", {14'h0, err_code}, h, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, output int s);
    uart_rx_data = b;
    uart_rx_done = 1'b1;
    s = cyc;
    tick(1);
    uart_rx_done = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((wr_q.size() + tx_q.size() + err_q.size()) != 0 && k < 1000) begin
      tick(1);
      k++;
    end
    tick(3);
    check(name, 32'(wr_q.size() + tx_q.size() + err_q.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int s;
    s = 0;
    for (int i = 0; i < v.n; i++) begin
      send(v.b[i], s);
      if (i < v.n - 1) tick(v.gap);
    end
    if (v.ok) wr_q.push_back('{val: {v.addr, v.data}, cyc: s + 1});
    else err_q.push_back('{val: 16'd1, cyc: s + 1});
    tx_q.push_back('{val: {8'h00, v.tx}, cyc: s + 2});
    drain({name, "_drain"});
    check({name, "_cnt"}, 32'(frame_ok_cnt), 32'(v.cnt));
    check({name, "_txdata"}, 32'(tx_data), 32'(v.tx));
    if (v.ok) check({name, "_hold"}, 32'({reg_addr, reg_wdata}), 32'({v.addr, v.data}));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   s, s2, c;
    vecs[0] = '{b: 48'hA5103CF10000, n: 4, gap: 0, ok: 1, addr: 8'h10, data: 8'h3C, tx: 8'h06, cnt: 16'd1};
    vecs[1] = '{b: 48'hA5103C000000, n: 4, gap: 1, ok: 0, addr: 8'h00, data: 8'h00, tx: 8'h15, cnt: 16'd1};
    vecs[2] = '{b: 48'hA50102A80000, n: 4, gap: 2, ok: 1, addr: 8'h01, data: 8'h02, tx: 8'h06, cnt: 16'd2};
    vecs[3] = '{b: 48'h00FFA5FFFFA3, n: 6, gap: 0, ok: 1, addr: 8'hFF, data: 8'hFF, tx: 8'h06, cnt: 16'd3};
    vecs[4] = '{b: 48'hA5A5A5EF0000, n: 4, gap: 1, ok: 1, addr: 8'hA5, data: 8'hA5, tx: 8'h06, cnt: 16'd4};
    vecs[5] = '{b: 48'hA58080A50000, n: 4, gap: 0, ok: 1, addr: 8'h80, data: 8'h80, tx: 8'h06, cnt: 16'd5};
    vecs[6] = '{b: 48'hA50000A60000, n: 4, gap: 3, ok: 0, addr: 8'h00, data: 8'h00, tx: 8'h15, cnt: 16'd5};

    rst_in = 1'b1;
    tick(3);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_reg_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_reg_addr", 32'({reg_addr, reg_wdata}), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_cnt", 32'(frame_ok_cnt), 32'd0);
    rst_in = 1'b0;
    tick(1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Silence after the address byte: timeout 100 cycles after its strobe.
    send(8'hA5, s);
    send(8'h10, s);
    err_q.push_back('{val: 16'd2, cyc: s + 100});
    tick(110);
    drain("timeout_drain");
    check("timeout_code_held", 32'(err_code), 32'd2);
    run_vec('{b: 48'hA50102A80000, n: 4, gap: 0, ok: 1, addr: 8'h01, data: 8'h02, tx: 8'h06,
              cnt: 16'd6}, "post_timeout");

    // A byte landing exactly on the would-be timeout cycle wins.
    send(8'hA5, s);
    tick(98);
    send(8'h10, s);
    send(8'h3C, s);
    send(8'hF1, s);
    wr_q.push_back('{val: 16'h103C, cyc: s + 1});
    tx_q.push_back('{val: 16'h0006, cyc: s + 2});
    drain("byte_wins_drain");
    check("byte_wins_cnt", 32'(frame_ok_cnt), 32'd7);

    // Long busy wait with an overrun byte in the middle.
    tx_busy = 1'b1;
    send(8'hA5, s);
    send(8'h10, s);
    send(8'h3C, s);
    send(8'hF1, s);
    wr_q.push_back('{val: 16'h103C, cyc: s + 1});
    tick(100);
    send(8'h55, s2);
    err_q.push_back('{val: 16'd3, cyc: s2 + 1});
    tick(398);
    tx_busy = 1'b0;
    c = cyc;
    tx_q.push_back('{val: 16'h0006, cyc: c + 1});
    drain("busy_drain");
    check("busy_cnt", 32'(frame_ok_cnt), 32'd8);
    check("busy_txdata", 32'(tx_data), 32'h06);

    // Overrun byte in the same cycle the transmitter frees up.
    tx_busy = 1'b1;
    send(8'hA5, s);
    send(8'h01, s);
    send(8'h02, s);
    send(8'hA8, s);
    wr_q.push_back('{val: 16'h0102, cyc: s + 1});
    tick(5);
    tx_busy = 1'b0;
    uart_rx_data = 8'h55;
    uart_rx_done = 1'b1;
    c = cyc;
    tx_q.push_back('{val: 16'h0006, cyc: c + 1});
    err_q.push_back('{val: 16'd3, cyc: c + 1});
    tick(1);
    uart_rx_done = 1'b0;
    drain("coincide_drain");
    check("coincide_cnt", 32'(frame_ok_cnt), 32'd9);

    // Reset in the middle of a frame.
    send(8'hA5, s);
    send(8'h10, s);
    rst_in = 1'b1;
    tick(2);
    check("midrst_cnt", 32'(frame_ok_cnt), 32'd0);
    check("midrst_txdata", 32'(tx_data), 32'd0);
    check("midrst_errcode", 32'(err_code), 32'd0);
    rst_in = 1'b0;
    run_vec('{b: 48'hA52030F50000, n: 4, gap: 0, ok: 1, addr: 8'h20, data: 8'h30, tx: 8'h06,
              cnt: 16'd1}, "post_rst");

    // Reset while a response waits on a busy transmitter: no tx_start may follow.
    tx_busy = 1'b1;
    send(8'hA5, s);
    send(8'h10, s);
    send(8'h3C, s);
    send(8'hF1, s);
    wr_q.push_back('{val: 16'h103C, cyc: s + 1});
    tick(3);
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    tx_busy = 1'b0;
    tick(10);
    drain("hs_rst_drain");
    check("hs_rst_cnt", 32'(frame_ok_cnt), 32'd0);
    check("hs_rst_txdata", 32'(tx_data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command controller placed downstream of the UART receive path. Consumes the received byte stream (byte + one-cycle done strobe) and parses fixed 4-byte write frames: header, address, data, checksum. Valid frames issue a single-cycle register write strobe to the board register bank. Every complete frame (valid or bad checksum) is answered with an ACK/NAK byte request to the UART transmit path through a start/busy handshake.

Parameters:
HEADER, 8'hA5, frame start byte.
ACK_BYTE, 8'h06, response byte for a valid frame.
NAK_BYTE, 8'h15, response byte for a checksum failure.
TIMEOUT_CYCLES, 32'd50_000, maximum clk_in cycles between bytes inside a frame (1 ms at 50 MHz).

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_in  input  1  synchronous reset, active-high
uart_rx_data  input  8  received byte; valid only while uart_rx_done=1
uart_rx_done  input  1  one-cycle strobe: new byte available
tx_busy  input  1  UART transmitter busy; a start request is accepted only while 0
tx_start  output  1  one-cycle request to transmit tx_data
tx_data  output  8  response byte; held stable from tx_start until the next response
reg_wr_en  output  1  one-cycle register write strobe
reg_addr  output  8  write address; valid while reg_wr_en=1, then held
reg_wdata  output  8  write data; valid while reg_wr_en=1, then held
err_pulse  output  1  one-cycle error strobe
err_code  output  2  1=checksum, 2=timeout, 3=overrun; held after err_pulse
frame_ok_cnt  output  16  count of valid frames; wraps 16'hFFFF->0

Behaviour:
- Reset (rst_in=1 at a clock edge): state=IDLE. tx_start, reg_wr_en and err_pulse are 0. tx_data, reg_addr, reg_wdata, err_code, frame_ok_cnt and the timeout counter are 0. Reset takes priority over all other events, including mid-frame and mid-handshake.
- States: IDLE, ADDR, DATA, CSUM, RESP.
- IDLE: on uart_rx_done with byte==HEADER, go to ADDR. Any other byte is ignored silently.
- ADDR: on uart_rx_done, latch the byte into an address shadow register and go to DATA.
- DATA: on uart_rx_done, latch the byte into a data shadow register and go to CSUM.
- CSUM: on uart_rx_done, compare the byte with (HEADER + addr + data) mod 256.
  - Match: on the next cycle, reg_wr_en=1 for exactly one cycle. reg_addr/reg_wdata take the shadow values in the same cycle. frame_ok_cnt increments. tx_data is set to ACK_BYTE. Go to RESP.
  - Mismatch: on the next cycle, err_pulse=1 with err_code=1. No write occurs. tx_data is set to NAK_BYTE. Go to RESP.
- RESP: in the first cycle with tx_busy=0, tx_start=1 for one cycle and the state returns to IDLE. If tx_busy stays 1, wait indefinitely; tx_start never repeats for the same response.
- Overrun: a uart_rx_done seen in RESP discards the byte and pulses err_pulse with err_code=3. The state stays RESP. If this coincides with the tx_start cycle, both outputs assert and the byte is still discarded.
- Timeout:
  - The counter clears in IDLE and on every uart_rx_done. It increments each cycle in ADDR, DATA and CSUM.
  - When it reaches TIMEOUT_CYCLES-1 with no uart_rx_done that cycle: err_pulse=1, err_code=2, state goes to IDLE. No response byte and no write.
  - A byte arriving in that same cycle wins, and no timeout fires.
  - RESP does not time out.
- Latency: 1 cycle from the checksum byte's uart_rx_done to reg_wr_en or err_pulse. tx_start follows at the earliest cycle after entering RESP with tx_busy=0 (minimum 2 cycles after the checksum strobe).
- A header byte received in ADDR, DATA or CSUM is treated as data; there is no resync.
- Arithmetic is 8-bit and wraps. Counters saturate nowhere except the frame_ok_cnt wrap.

Test Plan:
1. Reset, then bytes A5,10,3C,F1 (A5+10+3C=F1) with tx_busy=0 -> reg_wr_en one cycle with addr=10, wdata=3C; tx_start with tx_data=06; frame_ok_cnt=1.
2. Bytes A5,10,3C,00 -> no reg_wr_en; err_pulse with err_code=1; tx_start with tx_data=15; frame_ok_cnt unchanged.
3. TIMEOUT_CYCLES=100; bytes A5,10, then silence -> err_pulse with err_code=2 exactly 100 cycles after the 10 strobe; state returns to IDLE; no tx_start; next A5,01,02,A8 accepted.
4. Valid frame with tx_busy held 1 for 500 cycles, plus an extra byte 55 during the wait -> err_code=3 pulse; tx_start exactly once, on the first cycle after tx_busy falls; tx_data=06.
5. Bytes 00,FF,A5,FF,FF,A3 -> leading bytes ignored; write addr=FF, data=FF (checksum wraps to A3).
6. rst_in asserted after A5,10 of a frame, then A5,20,30,F5 -> no write from the aborted frame; write addr=20, data=30; frame_ok_cnt=1.
